// File: rtl/complex_mult_initiator.sv
// Operand FIFO + issue FSM + in-flight limiter + one-entry result register for the complex multiplier.
// Operand reaches op_val one edge after it lands in an empty FIFO; product is visible one edge after res handshake.

module cmi_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] head_dat,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign head_dat = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            mem_d[wr_ptr_q[AW-1:0]] = push_dat;
            wr_ptr_d = wr_ptr_q + (AW+1)'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + (AW+1)'(1);
        end
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end
endmodule

module complex_mult_initiator #(
    parameter int DATA_WIDTH      = 8,
    parameter int FIFO_DEPTH      = 4,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    in_val,
    output logic                    in_ready,
    input  logic [DATA_WIDTH-1:0]   in_op_1_re,
    input  logic [DATA_WIDTH-1:0]   in_op_1_im,
    input  logic [DATA_WIDTH-1:0]   in_op_2_re,
    input  logic [DATA_WIDTH-1:0]   in_op_2_im,
    output logic                    op_val,
    input  logic                    op_ready,
    output logic [DATA_WIDTH-1:0]   op_1_re,
    output logic [DATA_WIDTH-1:0]   op_1_im,
    output logic [DATA_WIDTH-1:0]   op_2_re,
    output logic [DATA_WIDTH-1:0]   op_2_im,
    input  logic                    res_val,
    output logic                    res_ready,
    input  logic [2*DATA_WIDTH-1:0] result_re,
    input  logic [2*DATA_WIDTH-1:0] result_im,
    output logic                    out_val,
    input  logic                    out_ready,
    output logic [2*DATA_WIDTH-1:0] out_re,
    output logic [2*DATA_WIDTH-1:0] out_im,
    output logic                    sw_rst,
    output logic [3:0]              outstanding,
    output logic                    proto_err
);
    typedef struct packed {
        logic [DATA_WIDTH-1:0] a_re;
        logic [DATA_WIDTH-1:0] a_im;
        logic [DATA_WIDTH-1:0] b_re;
        logic [DATA_WIDTH-1:0] b_im;
    } op_pair_t;

    typedef struct packed {
        logic [2*DATA_WIDTH-1:0] re;
        logic [2*DATA_WIDTH-1:0] im;
    } prod_t;

    typedef enum logic {IDLE, ISSUE} state_t;

    localparam logic [4:0] MAX_OS = 5'(MAX_OUTSTANDING);

    state_t   state_q, state_d;
    logic     op_val_q, op_val_d;
    op_pair_t op_q, op_d;
    logic     out_val_q, out_val_d;
    prod_t    out_q, out_d;
    logic     sw_rst_q, sw_rst_d;
    logic [3:0] outstanding_q, outstanding_d;
    logic     proto_err_q, proto_err_d;

    op_pair_t in_pair, head_pair;
    logic     fifo_full, fifo_empty, fifo_push, fifo_pop;
    logic     op_hs, res_hs, room_idle, room_b2b;

    assign in_pair   = '{a_re: in_op_1_re, a_im: in_op_1_im, b_re: in_op_2_re, b_im: in_op_2_im};
    assign in_ready  = !fifo_full && !sw_rst_q && !rst;
    assign res_ready = (!out_val_q || out_ready) && !sw_rst_q && !rst;
    assign fifo_push = in_val && in_ready && !flush;
    assign op_hs     = op_val_q && op_ready;
    assign res_hs    = res_val && res_ready;
    assign room_idle = {1'b0, outstanding_q} < MAX_OS;
    assign room_b2b  = ({1'b0, outstanding_q} + 5'd1) < MAX_OS;
    assign fifo_pop  = !flush && !fifo_empty &&
                       ((state_q == IDLE && room_idle) || (state_q == ISSUE && op_hs && room_b2b));

    cmi_fifo #(
        .WIDTH ($bits(op_pair_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_op_fifo (
        .clk      (clk),
        .rst      (rst),
        .clr      (flush),
        .push     (fifo_push),
        .push_dat (in_pair),
        .pop      (fifo_pop),
        .head_dat (head_pair),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    always_comb begin
        state_d       = state_q;
        op_val_d      = op_val_q;
        op_d          = op_q;
        out_val_d     = out_val_q;
        out_d         = out_q;
        outstanding_d = outstanding_q;
        proto_err_d   = proto_err_q;
        sw_rst_d      = flush;

        if (fifo_pop) begin
            op_d     = head_pair;
            op_val_d = 1'b1;
            state_d  = ISSUE;
        end else if (state_q == ISSUE && op_hs) begin
            op_val_d = 1'b0;
            state_d  = IDLE;
        end

        // A product arriving with nothing in flight is passed on but flagged.
        case ({op_hs, res_hs})
            2'b10: outstanding_d = outstanding_q + 4'd1;
            2'b01: begin
                if (outstanding_q == 4'd0) proto_err_d = 1'b1;
                else                       outstanding_d = outstanding_q - 4'd1;
            end
            default: ;
        endcase

        if (res_hs) begin
            out_d     = '{re: result_re, im: result_im};
            out_val_d = 1'b1;
        end else if (out_ready) begin
            out_val_d = 1'b0;
        end

        if (flush) begin
            state_d       = IDLE;
            op_val_d      = 1'b0;
            outstanding_d = 4'd0;
            out_val_d     = 1'b0;
            proto_err_d   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            op_val_q      <= 1'b0;
            op_q          <= '0;
            out_val_q     <= 1'b0;
            out_q         <= '0;
            sw_rst_q      <= 1'b0;
            outstanding_q <= 4'd0;
            proto_err_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            op_val_q      <= op_val_d;
            op_q          <= op_d;
            out_val_q     <= out_val_d;
            out_q         <= out_d;
            sw_rst_q      <= sw_rst_d;
            outstanding_q <= outstanding_d;
            proto_err_q   <= proto_err_d;
        end
    end

    assign op_val      = op_val_q;
    assign op_1_re     = op_q.a_re;
    assign op_1_im     = op_q.a_im;
    assign op_2_re     = op_q.b_re;
    assign op_2_im     = op_q.b_im;
    assign out_val     = out_val_q;
    assign out_re      = out_q.re;
    assign out_im      = out_q.im;
    assign sw_rst      = sw_rst_q;
    assign outstanding = outstanding_q;
    assign proto_err   = proto_err_q;
endmodule

// File: tb/tb_complex_mult_initiator.sv
// Bench for complex_mult_initiator: behavioural multiplier plus product/operand scoreboards.
module tb_complex_mult_initiator;
    localparam int DW = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, flush, in_val, in_ready, op_val, op_ready, res_val, res_ready;
    logic out_val, out_ready, sw_rst, proto_err;
    logic [DW-1:0]   in_op_1_re, in_op_1_im, in_op_2_re, in_op_2_im;
    logic [DW-1:0]   op_1_re, op_1_im, op_2_re, op_2_im;
    logic [2*DW-1:0] result_re, result_im, out_re, out_im;
    logic [3:0]      outstanding;

    complex_mult_initiator dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_val(in_val), .in_ready(in_ready),
        .in_op_1_re(in_op_1_re), .in_op_1_im(in_op_1_im),
        .in_op_2_re(in_op_2_re), .in_op_2_im(in_op_2_im),
        .op_val(op_val), .op_ready(op_ready),
        .op_1_re(op_1_re), .op_1_im(op_1_im), .op_2_re(op_2_re), .op_2_im(op_2_im),
        .res_val(res_val), .res_ready(res_ready),
        .result_re(result_re), .result_im(result_im),
        .out_val(out_val), .out_ready(out_ready), .out_re(out_re), .out_im(out_im),
        .sw_rst(sw_rst), .outstanding(outstanding), .proto_err(proto_err)
    );

    int n_chk = 0;
    int n_err = 0;

    logic [31:0] exp_q[$];
    logic [31:0] opnd_q[$];
    logic [31:0] mult_q[$];
    logic        res_en, res_force;
    logic [31:0] force_val;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] cmul(input logic signed [7:0] ar, input logic signed [7:0] ai,
                                         input logic signed [7:0] br, input logic signed [7:0] bi);
        logic signed [15:0] re, im;
        re = 16'(ar * br) - 16'(ai * bi);
        im = 16'(ar * bi) + 16'(ai * br);
        return {re, im};
    endfunction

    task automatic upd_mult();
        if (res_force) begin
            res_val = 1'b1;
            {result_re, result_im} = force_val;
        end else if (res_en && mult_q.size() != 0) begin
            res_val = 1'b1;
            {result_re, result_im} = mult_q[0];
        end else begin
            res_val = 1'b0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        upd_mult();
    endtask

    task automatic set_ops(input int k);
        in_op_1_re = 8'(k + 1);
        in_op_1_im = 8'(2 * k - 3);
        in_op_2_re = 8'(5 - k);
        in_op_2_im = 8'(3 * k);
    endtask

    task automatic drain(input string tag);
        int  c;
        logic done;
        done = 1'b0;
        for (c = 0; c < 200 && !done; c++) begin
            if (exp_q.size() == 0 && outstanding == 4'd0 && !out_val && !op_val) done = 1'b1;
            else tick();
        end
        check_eq(tag, 64'(done), 64'd1);
    endtask

    // Handshakes seen at the falling edge are the ones the next rising edge will take.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete(); opnd_q.delete(); mult_q.delete();
        end else begin
            if (out_val && out_ready) begin
                check_eq("sb_has_exp", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) check_eq("sb_out", {out_re, out_im}, exp_q.pop_front());
            end
            if (flush) begin
                exp_q.delete(); opnd_q.delete(); mult_q.delete();
            end else begin
                if (in_val && in_ready) begin
                    exp_q.push_back(cmul(in_op_1_re, in_op_1_im, in_op_2_re, in_op_2_im));
                    opnd_q.push_back({in_op_1_re, in_op_1_im, in_op_2_re, in_op_2_im});
                end
                if (op_val && op_ready) begin
                    check_eq("sb_has_opnd", 64'(opnd_q.size() != 0), 64'd1);
                    if (opnd_q.size() != 0)
                        check_eq("sb_issue", {op_1_re, op_1_im, op_2_re, op_2_im}, opnd_q.pop_front());
                    mult_q.push_back(cmul(op_1_re, op_1_im, op_2_re, op_2_im));
                end
                if (res_val && res_ready && !res_force && mult_q.size() != 0) void'(mult_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        int acc, idx, hs;
        logic [31:0] prod_a, prod_b;

        rst = 1; flush = 0; in_val = 0; set_ops(0);
        op_ready = 1; out_ready = 1; res_en = 0; res_force = 0; force_val = '0;
        upd_mult();

        // Reset state
        tick();
        check_eq("rst_op_val", 64'(op_val), 0);
        check_eq("rst_op", {op_1_re, op_1_im, op_2_re, op_2_im}, 0);
        check_eq("rst_out", {out_val, out_re, out_im}, 0);
        check_eq("rst_misc", {sw_rst, outstanding, proto_err}, 0);
        check_eq("rst_readies", {in_ready, res_ready}, 0);
        tick();
        rst = 0;
        #1;
        check_eq("rst_in_ready_after", 64'(in_ready), 1);

        // Test 1: single operation (3+4j)*(1+2j)
        in_val = 1;
        {in_op_1_re, in_op_1_im, in_op_2_re, in_op_2_im} = {8'd3, 8'd4, 8'd1, 8'd2};
        tick();
        in_val = 0;
        check_eq("t1_op_val_accept_edge", 64'(op_val), 0);
        tick();
        check_eq("t1_op_val", 64'(op_val), 1);
        check_eq("t1_op_1_re", 64'(op_1_re), 3);
        check_eq("t1_op_2_im", 64'(op_2_im), 2);
        tick();
        check_eq("t1_outstanding_1", 64'(outstanding), 1);
        res_en = 1; upd_mult();
        tick();
        check_eq("t1_out_val", 64'(out_val), 1);
        check_eq("t1_out_re", 64'(out_re), 64'hFFFB);
        check_eq("t1_out_im", 64'(out_im), 64'h000A);
        check_eq("t1_outstanding_0", 64'(outstanding), 0);
        tick();
        check_eq("t1_out_val_clear", 64'(out_val), 0);

        // Test 2: FIFO full with op_ready low
        res_en = 0; upd_mult(); op_ready = 0; acc = 0; idx = 0;
        for (int c = 0; c < 10; c++) begin
            in_val = 1; set_ops(idx);
            if (in_ready) begin acc++; idx++; end
            tick();
        end
        in_val = 0;
        check_eq("t2_accepted", 64'(acc), 5);
        check_eq("t2_in_ready_full", 64'(in_ready), 0);
        check_eq("t2_op_val_held", 64'(op_val), 1);
        check_eq("t2_outstanding", 64'(outstanding), 0);
        op_ready = 1; res_en = 1; upd_mult();
        drain("t2_drain");

        // Test 3: outstanding limit
        res_en = 0; upd_mult(); op_ready = 1; hs = 0;
        for (int c = 0; c < 4; c++) begin
            in_val = 1; set_ops(10 + c);
            if (op_val && op_ready) hs++;
            tick();
        end
        in_val = 0;
        for (int c = 0; c < 6; c++) begin
            if (op_val && op_ready) hs++;
            tick();
        end
        check_eq("t3_handshakes", 64'(hs), 2);
        check_eq("t3_op_val_stall", 64'(op_val), 0);
        check_eq("t3_outstanding_2", 64'(outstanding), 2);
        res_en = 1; upd_mult();
        tick();
        res_en = 0; upd_mult();
        check_eq("t3_outstanding_1", 64'(outstanding), 1);
        check_eq("t3_op_val_before", 64'(op_val), 0);
        tick();
        check_eq("t3_third_issue", 64'(op_val), 1);
        res_en = 1; upd_mult();
        drain("t3_drain");

        // Test 4: downstream backpressure
        res_en = 0; upd_mult(); out_ready = 0; op_ready = 1;
        prod_a = cmul(8'(21), 8'(37), 8'(-15), 8'(60));
        prod_b = cmul(8'(22), 8'(39), 8'(-16), 8'(63));
        for (int c = 0; c < 2; c++) begin
            in_val = 1; set_ops(20 + c);
            tick();
        end
        in_val = 0;
        for (int c = 0; c < 20 && outstanding != 4'd2; c++) tick();
        check_eq("t4_outstanding_2", 64'(outstanding), 2);
        res_en = 1; upd_mult();
        tick();
        check_eq("t4_out_a", {out_val, out_re, out_im}, {1'b1, prod_a});
        check_eq("t4_res_ready_low", 64'(res_ready), 0);
        check_eq("t4_b_held", 64'(res_val), 1);
        tick();
        check_eq("t4_out_a_hold", {out_val, out_re, out_im}, {1'b1, prod_a});
        check_eq("t4_outstanding_1", 64'(outstanding), 1);
        out_ready = 1;
        tick();
        check_eq("t4_out_b", {out_val, out_re, out_im}, {1'b1, prod_b});
        tick();
        check_eq("t4_out_done", {out_val, outstanding}, 0);

        // Test 5: flush mid-operation
        res_en = 0; upd_mult(); op_ready = 0;
        for (int c = 0; c < 4; c++) begin
            in_val = 1; set_ops(30 + c);
            tick();
        end
        in_val = 0;
        tick();
        op_ready = 1;
        tick();
        op_ready = 0;
        in_val = 1; set_ops(40);
        tick();
        in_val = 0;
        check_eq("t5_pre_op_val", 64'(op_val), 1);
        check_eq("t5_pre_outstanding", 64'(outstanding), 1);
        flush = 1; in_val = 1; set_ops(41);
        tick();
        flush = 0; in_val = 0;
        check_eq("t5_sw_rst", 64'(sw_rst), 1);
        check_eq("t5_cleared", {op_val, out_val, outstanding}, 0);
        check_eq("t5_readies_low", {in_ready, res_ready}, 0);
        tick();
        check_eq("t5_sw_rst_end", 64'(sw_rst), 0);
        check_eq("t5_in_ready", 64'(in_ready), 1);
        tick();
        check_eq("t5_fifo_empty", 64'(op_val), 0);
        op_ready = 1;

        // Test 6: product with nothing outstanding
        force_val = 32'h1234_8765;
        exp_q.push_back(force_val);
        res_force = 1; upd_mult();
        tick();
        res_force = 0; upd_mult();
        check_eq("t6_out", {out_val, out_re, out_im}, {1'b1, 32'h1234_8765});
        check_eq("t6_proto_err", 64'(proto_err), 1);
        check_eq("t6_outstanding", 64'(outstanding), 0);
        for (int c = 0; c < 3; c++) tick();
        check_eq("t6_proto_err_sticky", 64'(proto_err), 1);
        flush = 1;
        tick();
        flush = 0;
        check_eq("t6_proto_err_flush", 64'(proto_err), 0);
        tick();

        check_eq("sb_empty", 64'(exp_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
